// File: rtl/uart_tx_gen.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, one or two stop bits.
// Define UART_TX_HOLD_BUF_EN to add a one-word holding register for gapless back-to-back frames.
module uart_tx_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  S_DATA,
    output logic                  BUSY
);
    // state  | meaning
    // IDLE   | line high, waiting for a word
    // START  | start bit (low)
    // DATA   | data bits, LSB first
    // PARITY | parity bit
    // STOP   | stop bit(s), high
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam int CNT_W = PRESCALE_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    stop2_q, stop2_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    s_data_q, s_data_d;
    logic                    busy_q, busy_d;

    logic                    accept, tc, load_new, load_buf;
    logic [PRESCALE_W-1:0]   in_presc;
    logic [CNT_W-1:0]        bit_len_m1, stop_len_m1;

`ifdef UART_TX_HOLD_BUF_EN
    logic                    buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                    buf_par_en_q, buf_par_en_d;
    logic                    buf_par_typ_q, buf_par_typ_d;
    logic                    buf_stop2_q, buf_stop2_d;
    logic [PRESCALE_W-1:0]   buf_presc_q, buf_presc_d;

    assign DATA_READY = !buf_full_q;
`else
    assign DATA_READY = (state_q == IDLE);
`endif

    assign accept      = DATA_VALID && DATA_READY;
    assign tc          = (cnt_q == '0);
    assign in_presc    = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
    assign bit_len_m1  = {1'b0, presc_q} - CNT_W'(1);
    assign stop_len_m1 = stop2_q ? ({presc_q, 1'b0} - CNT_W'(1)) : bit_len_m1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        presc_d   = presc_q;
        load_new  = 1'b0;
        load_buf  = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
        buf_full_d    = buf_full_q;
        buf_data_d    = buf_data_q;
        buf_par_en_d  = buf_par_en_q;
        buf_par_typ_d = buf_par_typ_q;
        buf_stop2_d   = buf_stop2_q;
        buf_presc_d   = buf_presc_q;
`endif
        case (state_q)
            IDLE:   load_new = accept;
            START: begin
                if (tc) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = bit_len_m1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (!tc) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = bit_len_m1;
                end else if (par_en_q) begin
                    state_d = PARITY;
                    cnt_d   = bit_len_m1;
                end else begin
                    state_d = STOP;
                    cnt_d   = stop_len_m1;
                end
            end
            PARITY: begin
                if (tc) begin
                    state_d = STOP;
                    cnt_d   = stop_len_m1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (tc) begin
`ifdef UART_TX_HOLD_BUF_EN
                    // A word arriving on the very last stop cycle chains on directly too.
                    if (buf_full_q)  load_buf = 1'b1;
                    else if (accept) load_new = 1'b1;
                    else             state_d  = IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_new) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            stop2_d   = STOP2;
            presc_d   = in_presc;
        end
`ifdef UART_TX_HOLD_BUF_EN
        if (load_buf) begin
            data_d     = buf_data_q;
            par_en_d   = buf_par_en_q;
            par_typ_d  = buf_par_typ_q;
            stop2_d    = buf_stop2_q;
            presc_d    = buf_presc_q;
            buf_full_d = 1'b0;
        end
        if (accept && !load_new) begin
            buf_full_d    = 1'b1;
            buf_data_d    = P_DATA;
            buf_par_en_d  = PAR_EN;
            buf_par_typ_d = PAR_TYP;
            buf_stop2_d   = STOP2;
            buf_presc_d   = in_presc;
        end
`endif
        if (load_new || load_buf) begin
            state_d = START;
            idx_d   = '0;
            cnt_d   = {1'b0, presc_d} - CNT_W'(1);
        end

        // Line value is registered, so it is derived from the state being entered.
        case (state_d)
            START:   s_data_d = 1'b0;
            DATA:    s_data_d = data_d[idx_d];
            PARITY:  s_data_d = (^data_d) ^ par_typ_d;
            default: s_data_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            presc_q   <= PRESCALE_W'(1);
            s_data_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            presc_q   <= presc_d;
            s_data_q  <= s_data_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_full_q    <= 1'b0;
            buf_data_q    <= '0;
            buf_par_en_q  <= 1'b0;
            buf_par_typ_q <= 1'b0;
            buf_stop2_q   <= 1'b0;
            buf_presc_q   <= PRESCALE_W'(1);
        end else begin
            buf_full_q    <= buf_full_d;
            buf_data_q    <= buf_data_d;
            buf_par_en_q  <= buf_par_en_d;
            buf_par_typ_q <= buf_par_typ_d;
            buf_stop2_q   <= buf_stop2_d;
            buf_presc_q   <= buf_presc_d;
        end
    end
`endif

    assign S_DATA = s_data_q;
    assign BUSY   = busy_q;
endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: 8-bit instance for most frames, 7-bit instance for the two-stop frame.
module tb_uart_tx_gen;
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] p_data;
    logic       valid, pe, pt, s2;
    logic [7:0] presc;
    logic       rdy, sd, busy;

    logic [6:0] p7;
    logic       v7, rdy7, sd7, busy7;

    int total = 0;
    int bad   = 0;

`ifdef UART_TX_HOLD_BUF_EN
    localparam logic RDY_BUSY = 1'b1;
`else
    localparam logic RDY_BUSY = 1'b0;
`endif

    always #5 CLK = ~CLK;

    uart_tx_gen #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(p_data), .DATA_VALID(valid), .DATA_READY(rdy),
        .PAR_EN(pe), .PAR_TYP(pt), .STOP2(s2), .PRESCALE(presc), .S_DATA(sd), .BUSY(busy)
    );

    uart_tx_gen #(.DATA_WIDTH(7), .PRESCALE_W(8)) dut7 (
        .CLK(CLK), .RST(RST), .P_DATA(p7), .DATA_VALID(v7), .DATA_READY(rdy7),
        .PAR_EN(1'b0), .PAR_TYP(1'b0), .STOP2(1'b1), .PRESCALE(8'd3), .S_DATA(sd7), .BUSY(busy7)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sd"}, 32'(sd), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(rdy), 32'd1);
    endtask

    task automatic offer(input logic [7:0] d, input logic e, input logic t, input logic s,
                         input logic [7:0] ps);
        p_data = d;
        pe     = e;
        pt     = t;
        s2     = s;
        presc  = ps;
        valid  = 1'b1;
    endtask

    // bits[k] is the k-th bit on the line; each lasts p cycles. Cycle chg_at alters PRESCALE/PAR_TYP.
    task automatic expect_frame(input string tag, input logic [15:0] bits, input int nbits, input int p,
                                input logic chk_rdy, input logic exp_rdy, input int skip, input int chg_at);
        for (int i = skip; i < nbits * p; i++) begin
            if (i == chg_at) begin
                presc = 8'd2;
                pt    = 1'b1;
            end
            chk($sformatf("%s_sd_c%0d", tag, i), 32'(sd), 32'(bits[i / p]));
            chk($sformatf("%s_busy_c%0d", tag, i), 32'(busy), 32'd1);
            if (chk_rdy) chk($sformatf("%s_rdy_c%0d", tag, i), 32'(rdy), 32'(exp_rdy));
            tick();
        end
    endtask

    initial begin
        RST = 1'b1; valid = 1'b1; p_data = 8'hFF; pe = 1'b0; pt = 1'b0; s2 = 1'b0; presc = 8'd4;
        p7 = 7'h00; v7 = 1'b0;
        tick();
        tick();
        RST = 1'b0; valid = 1'b0;
        chk_idle("reset");
        chk("reset7_sd", 32'(sd7), 32'd1);
        chk("reset7_busy", 32'(busy7), 32'd0);
        tick();
        chk_idle("reset_hold");

        // 0xA5, even parity, PRESCALE 4: 11 bits, 44 cycles
        offer(8'hA5, 1'b1, 1'b0, 1'b0, 8'd4);
        chk("a5_acc_rdy", 32'(rdy), 32'd1);
        tick(); valid = 1'b0;
        expect_frame("a5", 16'b101_0100_1010, 11, 4, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("a5_end");

        offer(8'h07, 1'b1, 1'b1, 1'b0, 8'd2);
        tick(); valid = 1'b0;
        expect_frame("p07_odd", 16'b100_0000_1110, 11, 2, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("p07_odd_end");

        offer(8'h07, 1'b1, 1'b0, 1'b0, 8'd2);
        tick(); valid = 1'b0;
        expect_frame("p07_even", 16'b110_0000_1110, 11, 2, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("p07_even_end");

        // two stop bits appear as two identical high bit slots
        offer(8'hFF, 1'b1, 1'b1, 1'b1, 8'd2);
        tick(); valid = 1'b0;
        expect_frame("ff_stop2", 16'hFFE, 12, 2, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("ff_stop2_end");

        // PRESCALE 0 behaves as 1
        offer(8'h3C, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(); valid = 1'b0;
        expect_frame("presc0", 16'b10_0111_1000, 10, 1, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("presc0_end");

        // mid-frame config change leaves current frame alone
        offer(8'hA5, 1'b1, 1'b0, 1'b0, 8'd4);
        tick(); valid = 1'b0;
        expect_frame("mid", 16'b101_0100_1010, 11, 4, 1'b1, RDY_BUSY, 0, 10);
        chk_idle("mid_end");
        offer(8'hA5, 1'b1, pt, 1'b0, presc);
        tick(); valid = 1'b0;
        expect_frame("mid_next", 16'b111_0100_1010, 11, 2, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("mid_next_end");

        // reset 10 cycles into a frame, DATA_VALID high during the reset cycle
        offer(8'h5A, 1'b0, 1'b0, 1'b0, 8'd3);
        tick(); valid = 1'b0;
        repeat (9) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        RST = 1'b1; valid = 1'b1; p_data = 8'h00;
        tick();
        RST = 1'b0; valid = 1'b0;
        chk_idle("rst_mid");
        tick();
        chk_idle("rst_mid_hold");
        offer(8'h5A, 1'b0, 1'b0, 1'b0, 8'd3);
        tick(); valid = 1'b0;
        expect_frame("after_rst", 16'b10_1011_0100, 10, 3, 1'b1, RDY_BUSY, 0, -1);
        chk_idle("after_rst_end");

        // 7-bit instance: 0x55, no parity, two stop bits, PRESCALE 3 -> 30 cycles
        chk("d7_rdy", 32'(rdy7), 32'd1);
        p7 = 7'h55; v7 = 1'b1;
        tick(); v7 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            logic [9:0] f7;
            f7 = 10'b11_1010_1010;
            chk($sformatf("d7_sd_c%0d", i), 32'(sd7), 32'(f7[i / 3]));
            chk($sformatf("d7_busy_c%0d", i), 32'(busy7), 32'd1);
            tick();
        end
        chk("d7_end_sd", 32'(sd7), 32'd1);
        chk("d7_end_busy", 32'(busy7), 32'd0);
        chk("d7_end_rdy", 32'(rdy7), 32'd1);

`ifdef UART_TX_HOLD_BUF_EN
        offer(8'h5A, 1'b0, 1'b0, 1'b0, 8'd2);
        tick();
        chk("buf_rdy_empty", 32'(rdy), 32'd1);
        p_data = 8'hC3;
        tick(); valid = 1'b0;
        chk("buf_rdy_full", 32'(rdy), 32'd0);
        expect_frame("buf_w1", 16'b10_1011_0100, 10, 2, 1'b0, 1'b0, 1, -1);
        expect_frame("buf_w2", 16'b11_1000_0110, 10, 2, 1'b0, 1'b0, 0, -1);
        chk_idle("buf_end");
`else
        // second word held on the bus is ignored until the frame ends
        offer(8'h5A, 1'b0, 1'b0, 1'b0, 8'd2);
        tick();
        p_data = 8'hC3;
        expect_frame("nb_w1", 16'b10_1011_0100, 10, 2, 1'b1, 1'b0, 0, -1);
        chk_idle("nb_gap");
        tick(); valid = 1'b0;
        expect_frame("nb_w2", 16'b11_1000_0110, 10, 2, 1'b1, 1'b0, 0, -1);
        chk_idle("nb_end");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PRESCALE_W, default 8, width of the PRESCALE input.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  parallel data word.
REQ-006 SHALL have port DATA_VALID  input  1  P_DATA valid this cycle.
REQ-007 SHALL have port DATA_READY  output  1  block can accept a word this cycle.
REQ-008 SHALL have port PAR_EN  input  1  parity bit enabled.
REQ-009 SHALL have port PAR_TYP  input  1  parity type, 0 = even, 1 = odd.
REQ-010 SHALL have port STOP2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 SHALL have port PRESCALE  input  PRESCALE_W  CLK cycles per serial bit.
REQ-012 SHALL have port S_DATA  output  1  serial line, idle high, registered.
REQ-013 SHALL have port BUSY  output  1  frame in progress, registered.

Function
REQ-014 SHALL accept a word on any rising edge where DATA_VALID and DATA_READY are both 1; DATA_VALID while DATA_READY=0 is ignored and the word is not captured.
REQ-015 SHALL latch P_DATA, PAR_EN, PAR_TYP, STOP2 and PRESCALE at acceptance; input changes mid-frame have no effect on that frame.
REQ-016 SHALL treat latched PRESCALE=0 as 1.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on accept; START->DATA; DATA->DATA until DATA_WIDTH bits are sent, then ->PARITY if PAR_EN else ->STOP; PARITY->STOP; STOP->IDLE, or ->START per REQ-024.
REQ-018 SHALL hold each state's line value for exactly PRESCALE cycles (STOP for 2*PRESCALE when STOP2=1), using an internal cycle counter and a bit index of ceil(log2(DATA_WIDTH)) bits.
REQ-019 SHALL drive S_DATA: 1 in IDLE, 0 in START, data LSB first in DATA, parity bit in PARITY, 1 in STOP.
REQ-020 SHALL compute the parity bit as XOR of the latched data for even, inverted XOR for odd; PAR_TYP is ignored when PAR_EN=0.
REQ-021 SHALL drive S_DATA low starting on the cycle after the acceptance edge; latency is 1 cycle.
REQ-022 SHALL assert BUSY from the cycle after acceptance through the last STOP cycle, and deassert it in IDLE.
REQ-023 SHALL set frame length to (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) * PRESCALE cycles.
REQ-024 Without the buffer: DATA_READY=1 only in IDLE, and at least one IDLE cycle separates frames.

Reset
REQ-025 On RST=1 at a clock edge, including mid-frame, SHALL next cycle give: state IDLE, S_DATA=1, BUSY=0, DATA_READY=1, counters 0, buffer empty; no partial frame resumes.
REQ-026 SHALL ignore DATA_VALID during the reset cycle.

Configuration
REQ-027 Macro UART_TX_HOLD_BUF_EN, when defined, SHALL add one holding register (data plus config): DATA_READY = buffer empty in all states; a word accepted while BUSY is stored; at the end of the last STOP cycle a full buffer moves straight to START with no IDLE gap, and BUSY stays 1.
REQ-028 Without UART_TX_HOLD_BUF_EN, SHALL behave per REQ-024 with no holding register.

Verification
REQ-029 DATA_WIDTH=8, PRESCALE=4, PAR_EN=1, PAR_TYP=0, STOP2=0, P_DATA=0xA5 -> S_DATA bits 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles, for 44 cycles; BUSY high for 44 cycles.
REQ-030 PAR_TYP=1, P_DATA=0x07, PRESCALE=2 -> parity bit 0; PAR_TYP=0 with the same data -> parity bit 1.
REQ-031 DATA_WIDTH=7, PAR_EN=0, STOP2=1, PRESCALE=3, P_DATA=0x55 -> 10-bit frame of 30 cycles, with the final 6 cycles high.
REQ-032 RST pulsed 10 cycles into a frame -> S_DATA=1, BUSY=0, DATA_READY=1 next cycle; a new word then gives a clean full frame.
REQ-033 Change PRESCALE and PAR_TYP mid-frame -> current frame unchanged; next frame uses the new values.
REQ-034 With UART_TX_HOLD_BUF_EN, two words offered back-to-back -> second accepted while BUSY, its start bit follows the last stop cycle immediately, and BUSY never drops; without the macro -> DATA_READY=0 until IDLE.
